// File: rtl/beam_sweep_controller_pkg.sv
// beam_pkg: shared types and constants for the beam sweep controller.
//   sweep_state_t     - controller FSM states
//   SIN_WIDTH_DEFAULT - default magnitude width; SIN_ONE is 1.0 at that width
//   sin_q15()         - |sin| for 0..90 deg in 5 deg steps, Q1.15, rounded to nearest
//   max3()            - helper used to size the shared cycle counter
package beam_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_FIRE,
        ST_LISTEN,
        ST_ADVANCE
    } sweep_state_t;

    localparam int SIN_WIDTH_DEFAULT = 16;
    localparam int SIN_ONE           = 2 ** (SIN_WIDTH_DEFAULT - 1);
    localparam int SIN_TABLE_IDX_W   = 5;

    // Index is |angle|/5. 90 deg is exactly 32768, which still fits an
    // unsigned 16-bit magnitude.
    function automatic logic [15:0] sin_q15(input logic [SIN_TABLE_IDX_W-1:0] idx);
        logic [15:0] v;
        case (idx)
            5'd0:    v = 16'd0;
            5'd1:    v = 16'd2856;
            5'd2:    v = 16'd5690;
            5'd3:    v = 16'd8481;
            5'd4:    v = 16'd11207;
            5'd5:    v = 16'd13848;
            5'd6:    v = 16'd16384;
            5'd7:    v = 16'd18795;
            5'd8:    v = 16'd21063;
            5'd9:    v = 16'd23170;
            5'd10:   v = 16'd25102;
            5'd11:   v = 16'd26842;
            5'd12:   v = 16'd28378;
            5'd13:   v = 16'd29698;
            5'd14:   v = 16'd30792;
            5'd15:   v = 16'd31651;
            5'd16:   v = 16'd32270;
            5'd17:   v = 16'd32643;
            5'd18:   v = 16'd32768;
            default: v = 16'd0;
        endcase
        return v;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/beam_sweep_controller_if.sv
// beam_sweep_controller_if: control and beamformer-facing signals of the sweep controller.
//   master - top-level control / beamformer side (drives start/stop/continuous/rx_done)
//   slave  - the controller itself (drives sin/sign/angle, tx/listen enables, status pulses)
interface beam_sweep_controller_if
    import beam_pkg::*;
#(
    parameter int SIN_WIDTH = SIN_WIDTH_DEFAULT
);

    logic                 start_in;
    logic                 stop_in;
    logic                 continuous_in;
    logic                 rx_done_in;
    logic [SIN_WIDTH-1:0] sin_theta_out;
    logic                 sign_bit_out;
    logic signed [7:0]    angle_deg_out;
    logic                 tx_enable_out;
    logic                 listen_out;
    logic                 timeout_out;
    logic                 sweep_done_out;
    logic                 busy_out;

    modport master (
        output start_in, stop_in, continuous_in, rx_done_in,
        input  sin_theta_out, sign_bit_out, angle_deg_out, tx_enable_out,
               listen_out, timeout_out, sweep_done_out, busy_out
    );

    modport slave (
        input  start_in, stop_in, continuous_in, rx_done_in,
        output sin_theta_out, sign_bit_out, angle_deg_out, tx_enable_out,
               listen_out, timeout_out, sweep_done_out, busy_out
    );

endinterface

// File: rtl/beam_sweep_controller_sin_lut.sv
// sin_lut: registered |sin| lookup, one cycle of latency.
//   clk     - system clock
//   idx_in  - |angle|/5, 0..18
//   mag_out - |sin(angle)| in Q1.(SIN_WIDTH-1)
// The table is held at Q1.15; other widths are derived by shifting, with
// round-to-nearest when narrowing.
module sin_lut
    import beam_pkg::*;
#(
    parameter int SIN_WIDTH = SIN_WIDTH_DEFAULT
) (
    input  logic                       clk,
    input  logic [SIN_TABLE_IDX_W-1:0] idx_in,
    output logic [SIN_WIDTH-1:0]       mag_out
);

    logic [15:0]          q15;
    logic [SIN_WIDTH-1:0] mag_d;
    logic [SIN_WIDTH-1:0] mag_q;

    always_comb q15 = sin_q15(idx_in);

    generate
        if (SIN_WIDTH >= 16) begin : g_widen
            always_comb mag_d = SIN_WIDTH'(q15) << (SIN_WIDTH - 16);
        end else begin : g_narrow
            localparam int SH = 16 - SIN_WIDTH;
            logic [16:0] rounded;
            always_comb begin
                rounded = {1'b0, q15} + 17'(1 << (SH - 1));
                mag_d   = SIN_WIDTH'(rounded >> SH);
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        mag_q <= mag_d;
    end

    assign mag_out = mag_q;

endmodule

// File: rtl/beam_sweep_controller.sv
// beam_sweep_controller: steps the transmit beamformer through -MAX..+MAX degrees.
// Per angle: LOAD (latch sin/sign/angle) -> SETTLE -> FIRE (tx burst) ->
// LISTEN (until rx_done or timeout) -> ADVANCE.
//   clk    - system clock
//   rst_in - synchronous active-high reset
//   bus    - slave side of beam_sweep_controller_if (controls in, beam/status out)
module beam_sweep_controller
    import beam_pkg::*;
#(
    parameter int MAX_ANGLE_DEG  = 60,
    parameter int ANGLE_STEP_DEG = 10,
    parameter int SIN_WIDTH      = SIN_WIDTH_DEFAULT,
    parameter int SETTLE_CYCLES  = 16,
    parameter int BURST_CYCLES   = 524288,
    parameter int LISTEN_CYCLES  = 4194304
) (
    input  logic                      clk,
    input  logic                      rst_in,
    beam_sweep_controller_if.slave    bus
);

    localparam int NUM_STEPS = 2 * MAX_ANGLE_DEG / ANGLE_STEP_DEG + 1;
    localparam int IDX_W     = $clog2(NUM_STEPS + 1);
    localparam int STEP_DIV5 = ANGLE_STEP_DEG / 5;
    localparam int MAX_DIV5  = MAX_ANGLE_DEG / 5;
    localparam int CNT_MAX   = max3(SETTLE_CYCLES, BURST_CYCLES, LISTEN_CYCLES);
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(NUM_STEPS - 1);
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  BURST_LAST  = CNT_W'(BURST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  LISTEN_LAST = CNT_W'(LISTEN_CYCLES - 1);
    localparam logic signed [7:0] ANGLE_RESET = 8'(-MAX_ANGLE_DEG);

    function automatic logic signed [7:0] angle_of(input logic [IDX_W-1:0] idx);
        int a;
        a = int'(idx) * ANGLE_STEP_DEG - MAX_ANGLE_DEG;
        return 8'(a);
    endfunction

    // |angle|/5 without a divider: MAX and STEP are both multiples of 5.
    function automatic logic [SIN_TABLE_IDX_W-1:0] lut_index_of(input logic [IDX_W-1:0] idx);
        int m;
        m = int'(idx) * STEP_DIV5 - MAX_DIV5;
        if (m < 0) m = -m;
        return SIN_TABLE_IDX_W'(m);
    endfunction

    sweep_state_t               state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [IDX_W-1:0]           index_q, index_d;
    logic [SIN_WIDTH-1:0]       sin_q, sin_d;
    logic                       sign_q, sign_d;
    logic signed [7:0]          angle_q, angle_d;
    logic                       tx_q, tx_d;
    logic                       listen_q, listen_d;
    logic                       timeout_q, timeout_d;
    logic                       done_q, done_d;
    logic                       busy_q, busy_d;

    logic [SIN_TABLE_IDX_W-1:0] lut_idx;
    logic [SIN_WIDTH-1:0]       lut_mag;
    logic signed [7:0]          angle_cur;

    // The LUT is addressed with the *next* index so that its registered
    // output already matches index_q during the single LOAD cycle.
    sin_lut #(
        .SIN_WIDTH (SIN_WIDTH)
    ) u_sin_lut (
        .clk     (clk),
        .idx_in  (lut_idx),
        .mag_out (lut_mag)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        index_d   = index_q;
        sin_d     = sin_q;
        sign_d    = sign_q;
        angle_d   = angle_q;
        timeout_d = 1'b0;
        done_d    = 1'b0;
        angle_cur = angle_of(index_q);

        case (state_q)
            ST_IDLE: begin
                if (bus.start_in) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                sin_d   = lut_mag;
                sign_d  = angle_cur[7];
                angle_d = angle_cur;
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) state_d = ST_FIRE;
                else                      cnt_d   = cnt_q + CNT_W'(1);
            end
            ST_FIRE: begin
                if (cnt_q == BURST_LAST) state_d = ST_LISTEN;
                else                     cnt_d   = cnt_q + CNT_W'(1);
            end
            ST_LISTEN: begin
                // rx_done wins over a coincident final timeout cycle.
                if (bus.rx_done_in) begin
                    state_d = ST_ADVANCE;
                end else if (cnt_q == LISTEN_LAST) begin
                    state_d   = ST_ADVANCE;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_ADVANCE: begin
                if (index_q != LAST_IDX) begin
                    index_d = index_q + IDX_W'(1);
                    state_d = ST_LOAD;
                end else begin
                    done_d  = 1'b1;
                    index_d = '0;
                    state_d = bus.continuous_in ? ST_LOAD : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort overrides everything, including a completing sweep.
        if (bus.stop_in && (state_q != ST_IDLE)) begin
            state_d   = ST_IDLE;
            index_d   = '0;
            sin_d     = '0;
            sign_d    = 1'b0;
            angle_d   = ANGLE_RESET;
            timeout_d = 1'b0;
            done_d    = 1'b0;
        end

        if (state_d != state_q) cnt_d = '0;

        tx_d     = (state_d == ST_FIRE);
        listen_d = (state_d == ST_LISTEN);
        busy_d   = (state_d != ST_IDLE);
        lut_idx  = lut_index_of(index_d);
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            index_q   <= '0;
            sin_q     <= '0;
            sign_q    <= 1'b0;
            angle_q   <= ANGLE_RESET;
            tx_q      <= 1'b0;
            listen_q  <= 1'b0;
            timeout_q <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            index_q   <= index_d;
            sin_q     <= sin_d;
            sign_q    <= sign_d;
            angle_q   <= angle_d;
            tx_q      <= tx_d;
            listen_q  <= listen_d;
            timeout_q <= timeout_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.sin_theta_out  = sin_q;
    assign bus.sign_bit_out   = sign_q;
    assign bus.angle_deg_out  = angle_q;
    assign bus.tx_enable_out  = tx_q;
    assign bus.listen_out     = listen_q;
    assign bus.timeout_out    = timeout_q;
    assign bus.sweep_done_out = done_q;
    assign bus.busy_out       = busy_q;

endmodule
